// File: rtl/segment_swapchain_n_if.sv
// Settings/status bundle between the controller registers, the swapchain and
// the per-segment readers.
//   master: drives SYS_TIME, settings (UPDATE_SETTINGS, REQ_RD_SEGMENT,
//           TRANSITION_MODE, TRANSITION_VALUE, CYCLE, REP), SYNC_IDX, GPIO_IN,
//           EXT_MASK; observes SEGMENT, IDX, STOP, BUSY, DONE.
//   slave:  the swapchain itself (mirror directions).
interface segment_swapchain_n_if #(
    parameter int NUM_SEGMENT = 4,
    parameter int IDX_WIDTH   = 15,
    parameter int REP_WIDTH   = 16,
    parameter int NUM_GPIO    = 4
);
    localparam int SEG_W = $clog2(NUM_SEGMENT);

    logic [63:0]          SYS_TIME;
    logic                 UPDATE_SETTINGS;
    logic [SEG_W-1:0]     REQ_RD_SEGMENT;
    logic [7:0]           TRANSITION_MODE;
    logic [63:0]          TRANSITION_VALUE;
    logic [IDX_WIDTH-1:0] CYCLE    [NUM_SEGMENT];
    logic [REP_WIDTH-1:0] REP      [NUM_SEGMENT];
    logic [IDX_WIDTH-1:0] SYNC_IDX [NUM_SEGMENT];
    logic [NUM_GPIO-1:0]  GPIO_IN;
    logic [NUM_SEGMENT-1:0] EXT_MASK;

    logic [SEG_W-1:0]     SEGMENT;
    logic [IDX_WIDTH-1:0] IDX      [NUM_SEGMENT];
    logic                 STOP;
    logic                 BUSY;
    logic                 DONE;

    modport master (
        output SYS_TIME, UPDATE_SETTINGS, REQ_RD_SEGMENT, TRANSITION_MODE,
               TRANSITION_VALUE, CYCLE, REP, SYNC_IDX, GPIO_IN, EXT_MASK,
        input  SEGMENT, IDX, STOP, BUSY, DONE
    );

    modport slave (
        input  SYS_TIME, UPDATE_SETTINGS, REQ_RD_SEGMENT, TRANSITION_MODE,
               TRANSITION_VALUE, CYCLE, REP, SYNC_IDX, GPIO_IN, EXT_MASK,
        output SEGMENT, IDX, STOP, BUSY, DONE
    );
endinterface

// File: rtl/segment_swapchain_n.sv
// N-segment swapchain: selects which buffered segment drives playback, produces
// per-segment read indices and STOP/DONE/BUSY status for the sampler.
// Ports:
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   bus    segment_swapchain_n_if.slave (settings in, SEGMENT/IDX/STOP/BUSY/DONE out)
module segment_swapchain_n #(
    parameter int NUM_SEGMENT = 4,
    parameter int IDX_WIDTH   = 15,
    parameter int REP_WIDTH   = 16,
    parameter int NUM_GPIO    = 4,
    parameter int LATENCY     = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    segment_swapchain_n_if.slave   bus
);
    localparam int SEG_W  = $clog2(NUM_SEGMENT);
    localparam int GPIO_W = $clog2(NUM_GPIO);
    localparam int DCNT_W = $clog2(LATENCY + 1);

    localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_MODE_EXT       = 8'hF0;
    localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

    typedef enum logic [1:0] {
        INFINITE_LOOP,
        WAIT_START,
        FINITE_LOOP,
        STOPPED
    } state_e;

    typedef enum logic {
        IDX_SYNC,
        IDX_TIC
    } idx_mode_e;

    state_e               state_q, state_d;
    idx_mode_e            idx_mode_q, idx_mode_d;
    logic                 ext_mode_q, ext_mode_d;
    logic [SEG_W-1:0]     segment_q, segment_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic [SEG_W-1:0]     req_q, req_d;
    logic [REP_WIDTH-1:0] rep_q, rep_d;
    logic [REP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
    logic [DCNT_W-1:0]    diff_cnt_q, diff_cnt_d;
    logic [LATENCY-1:0]   ge_pipe_q, ge_pipe_d;
    logic [IDX_WIDTH-1:0] idx_old_q [NUM_SEGMENT];
    logic [IDX_WIDTH-1:0] idx_old_d [NUM_SEGMENT];
    logic [IDX_WIDTH-1:0] tic_idx_q [NUM_SEGMENT];
    logic [IDX_WIDTH-1:0] tic_idx_d [NUM_SEGMENT];

    logic [NUM_SEGMENT-1:0] changed;
    logic [SEG_W-1:0]     ext_next;
    logic                 req_ok;
    logic                 fire;
    logic                 fire_tic;
    logic                 loop_end;

    // Index history and change detection.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SEGMENT; i++) begin
            idx_old_d[i] = bus.SYNC_IDX[i];
            changed[i]   = (idx_old_q[i] != bus.SYNC_IDX[i]);
        end
    end

    // The signed 65-bit difference of two zero-extended 64-bit values is
    // non-negative exactly when SYS_TIME >= TRANSITION_VALUE; that single bit
    // is what travels down the LATENCY-deep pipeline.
    always_comb begin
        ge_pipe_d    = ge_pipe_q;
        ge_pipe_d[0] = (bus.SYS_TIME >= bus.TRANSITION_VALUE);
        for (int unsigned i = 1; i < LATENCY; i++) begin
            ge_pipe_d[i] = ge_pipe_q[i-1];
        end
    end

    // Next set EXT_MASK bit circularly above the current segment.
    always_comb begin
        logic        found;
        int unsigned cand;
        ext_next = segment_q;
        found    = 1'b0;
        for (int unsigned k = 1; k < NUM_SEGMENT; k++) begin
            cand = 32'(segment_q) + k;
            if (cand >= NUM_SEGMENT) begin
                cand = cand - NUM_SEGMENT;
            end
            if (!found && bus.EXT_MASK[cand]) begin
                ext_next = SEG_W'(cand);
                found    = 1'b1;
            end
        end
    end

    assign req_ok = ({1'b0, bus.REQ_RD_SEGMENT} < (SEG_W + 1)'(NUM_SEGMENT));

    always_comb begin
        state_d    = state_q;
        idx_mode_d = idx_mode_q;
        ext_mode_d = ext_mode_q;
        segment_d  = segment_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        req_d      = req_q;
        rep_d      = rep_q;
        loop_cnt_d = loop_cnt_q;
        diff_cnt_d = diff_cnt_q;
        tic_idx_d  = tic_idx_q;
        fire       = 1'b0;
        fire_tic   = 1'b0;
        loop_end   = 1'b0;

        if (bus.UPDATE_SETTINGS && req_ok) begin
            req_d = bus.REQ_RD_SEGMENT;
            rep_d = bus.REP[bus.REQ_RD_SEGMENT];
            if ((&bus.REP[bus.REQ_RD_SEGMENT]) ||
                (bus.TRANSITION_MODE == TRANSITION_MODE_IMMEDIATE)) begin
                segment_d  = bus.REQ_RD_SEGMENT;
                stop_d     = 1'b0;
                idx_mode_d = IDX_SYNC;
                ext_mode_d = (bus.TRANSITION_MODE == TRANSITION_MODE_EXT);
                if (!(&bus.REP[bus.REQ_RD_SEGMENT])) begin
                    state_d    = FINITE_LOOP;
                    loop_cnt_d = '0;
                end else begin
                    state_d = INFINITE_LOOP;
                end
            end else begin
                diff_cnt_d = DCNT_W'(LATENCY - 1);
                state_d    = WAIT_START;
            end
        end else begin
            case (state_q)
                INFINITE_LOOP: begin
                    if (ext_mode_q && changed[segment_q] &&
                        (bus.SYNC_IDX[segment_q] == '0)) begin
                        segment_d = ext_next;
                    end
                end
                WAIT_START: begin
                    case (bus.TRANSITION_MODE)
                        TRANSITION_MODE_SYNC_IDX: begin
                            fire = changed[req_q] && (bus.SYNC_IDX[req_q] == '0);
                        end
                        TRANSITION_MODE_SYS_TIME: begin
                            // Hold off until the pipeline carries a comparison
                            // made against the current TRANSITION_VALUE.
                            if (diff_cnt_q != '0) begin
                                diff_cnt_d = diff_cnt_q - 1'b1;
                            end else begin
                                fire     = ge_pipe_q[LATENCY-1];
                                fire_tic = 1'b1;
                            end
                        end
                        TRANSITION_MODE_GPIO: begin
                            fire     = changed[req_q] &&
                                       bus.GPIO_IN[bus.TRANSITION_VALUE[GPIO_W-1:0]];
                            fire_tic = 1'b1;
                        end
                        default: ;
                    endcase
                    if (fire) begin
                        segment_d  = req_q;
                        stop_d     = 1'b0;
                        loop_cnt_d = '0;
                        state_d    = FINITE_LOOP;
                        if (fire_tic) begin
                            idx_mode_d       = IDX_TIC;
                            tic_idx_d[req_q] = '0;
                        end else begin
                            idx_mode_d = IDX_SYNC;
                        end
                    end
                end
                FINITE_LOOP: begin
                    if (idx_mode_q == IDX_SYNC) begin
                        loop_end = changed[segment_q] && (bus.SYNC_IDX[segment_q] == '0);
                    end else if (changed[segment_q]) begin
                        if (tic_idx_q[segment_q] == bus.CYCLE[segment_q]) begin
                            tic_idx_d[segment_q] = '0;
                            loop_end             = 1'b1;
                        end else begin
                            tic_idx_d[segment_q] = tic_idx_q[segment_q] + 1'b1;
                        end
                    end
                    if (loop_end) begin
                        if (loop_cnt_q == rep_q) begin
                            stop_d  = 1'b1;
                            done_d  = 1'b1;
                            state_d = STOPPED;
                        end else begin
                            loop_cnt_d = loop_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= INFINITE_LOOP;
            idx_mode_q <= IDX_SYNC;
            ext_mode_q <= 1'b0;
            segment_q  <= '0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
            req_q      <= '0;
            rep_q      <= '0;
            loop_cnt_q <= '0;
            diff_cnt_q <= '0;
            ge_pipe_q  <= '0;
            for (int unsigned i = 0; i < NUM_SEGMENT; i++) begin
                idx_old_q[i] <= '0;
                tic_idx_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_mode_q <= idx_mode_d;
            ext_mode_q <= ext_mode_d;
            segment_q  <= segment_d;
            stop_q     <= stop_d;
            done_q     <= done_d;
            req_q      <= req_d;
            rep_q      <= rep_d;
            loop_cnt_q <= loop_cnt_d;
            diff_cnt_q <= diff_cnt_d;
            ge_pipe_q  <= ge_pipe_d;
            idx_old_q  <= idx_old_d;
            tic_idx_q  <= tic_idx_d;
        end
    end

    assign bus.SEGMENT = segment_q;
    assign bus.STOP    = stop_q;
    assign bus.DONE    = done_q;
    assign bus.BUSY    = (state_q == WAIT_START);

    always_comb begin
        for (int unsigned i = 0; i < NUM_SEGMENT; i++) begin
            bus.IDX[i] = (idx_mode_q == IDX_SYNC) ? idx_old_q[i] : tic_idx_q[i];
        end
    end
endmodule

// File: tb/tb_segment_swapchain_n.sv
module tb_segment_swapchain_n;
    localparam int NSEG = 4;
    localparam int LAT  = 5;
    localparam logic [7:0] M_SYNC = 8'h00;
    localparam logic [7:0] M_TIME = 8'h01;
    localparam logic [7:0] M_GPIO = 8'h02;
    localparam logic [7:0] M_EXT  = 8'hF0;
    localparam logic [7:0] M_IMM  = 8'hFF;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    segment_swapchain_n_if #(.NUM_SEGMENT(NSEG), .IDX_WIDTH(15), .REP_WIDTH(16),
                             .NUM_GPIO(4)) bus ();

    segment_swapchain_n #(.NUM_SEGMENT(NSEG), .IDX_WIDTH(15), .REP_WIDTH(16),
                          .NUM_GPIO(4), .LATENCY(LAT)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_step(input int seg, input int val);
        bus.SYNC_IDX[seg] = 15'(val);
        step();
    endtask

    task automatic do_update(input int seg, input logic [7:0] mode);
        bus.REQ_RD_SEGMENT  = 2'(seg);
        bus.TRANSITION_MODE = mode;
        bus.UPDATE_SETTINGS = 1'b1;
        step();
        bus.UPDATE_SETTINGS = 1'b0;
    endtask

    initial begin
        int      cycles;
        logic    switched;
        longint  sys_at_fire;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.SYS_TIME = '0;
        bus.UPDATE_SETTINGS = 1'b0;
        bus.REQ_RD_SEGMENT = '0;
        bus.TRANSITION_MODE = M_SYNC;
        bus.TRANSITION_VALUE = '0;
        bus.GPIO_IN = '0;
        bus.EXT_MASK = '0;
        for (int i = 0; i < NSEG; i++) begin
            bus.CYCLE[i] = 15'd3;
            bus.REP[i] = '1;
            bus.SYNC_IDX[i] = '0;
        end

        // Reset and idle index path
        step();
        step();
        check("rst_segment", 64'(bus.SEGMENT), 0);
        check("rst_stop", 64'(bus.STOP), 0);
        check("rst_busy", 64'(bus.BUSY), 0);
        check("rst_done", 64'(bus.DONE), 0);
        rst_n = 1'b1;
        bus.SYNC_IDX[0] = 15'd7;
        #1;
        check("idx0_before_edge", 64'(bus.IDX[0]), 0);
        step();
        check("idx0_delayed", 64'(bus.IDX[0]), 7);
        sync_step(0, 8);
        check("idx0_ramp", 64'(bus.IDX[0]), 8);
        check("idle_segment", 64'(bus.SEGMENT), 0);

        // SYNC_IDX transition to segment 2, REP=1 -> two loops
        sync_step(2, 1);
        bus.REP[2] = 16'd1;
        do_update(2, M_SYNC);
        check("sync_busy", 64'(bus.BUSY), 1);
        sync_step(2, 2);
        sync_step(2, 3);
        check("sync_still_busy", 64'(bus.BUSY), 1);
        check("sync_seg_hold", 64'(bus.SEGMENT), 0);
        sync_step(2, 0);
        check("sync_fired_busy", 64'(bus.BUSY), 0);
        check("sync_fired_seg", 64'(bus.SEGMENT), 2);
        for (int v = 1; v <= 3; v++) sync_step(2, v);
        sync_step(2, 0);
        check("sync_loop1_stop", 64'(bus.STOP), 0);
        check("sync_loop1_done", 64'(bus.DONE), 0);
        for (int v = 1; v <= 3; v++) sync_step(2, v);
        sync_step(2, 0);
        check("sync_loop2_stop", 64'(bus.STOP), 1);
        check("sync_loop2_done", 64'(bus.DONE), 1);
        step();
        check("sync_done_pulse", 64'(bus.DONE), 0);
        check("sync_stop_hold", 64'(bus.STOP), 1);

        // SYS_TIME transition to segment 1, REP=0, CYCLE=3
        bus.REP[1] = 16'd0;
        bus.TRANSITION_VALUE = 64'd1000;
        bus.SYS_TIME = 64'd990;
        do_update(1, M_TIME);
        switched = 1'b0;
        cycles = 0;
        sys_at_fire = 0;
        for (int n = 0; n < 40; n++) begin
            bus.SYS_TIME = bus.SYS_TIME + 64'd1;
            sys_at_fire = longint'(bus.SYS_TIME);
            step();
            cycles++;
            if (!bus.BUSY) begin
                switched = 1'b1;
                break;
            end
        end
        check("time_switched", 64'(switched), 1);
        check("time_not_early", 64'(sys_at_fire >= 1000), 1);
        check("time_not_late", 64'(sys_at_fire <= 1000 + LAT + 1), 1);
        check("time_min_latency", 64'(cycles >= LAT), 1);
        check("time_seg", 64'(bus.SEGMENT), 1);
        check("time_idx_start", 64'(bus.IDX[1]), 0);
        sync_step(1, 1);
        check("tic_1", 64'(bus.IDX[1]), 1);
        sync_step(1, 2);
        check("tic_2", 64'(bus.IDX[1]), 2);
        sync_step(1, 3);
        check("tic_3", 64'(bus.IDX[1]), 3);
        check("tic_3_stop", 64'(bus.STOP), 0);
        sync_step(1, 4);
        check("tic_wrap", 64'(bus.IDX[1]), 0);
        check("tic_wrap_stop", 64'(bus.STOP), 1);
        check("tic_wrap_done", 64'(bus.DONE), 1);
        sync_step(1, 5);
        check("tic_frozen", 64'(bus.IDX[1]), 0);
        check("tic_done_once", 64'(bus.DONE), 0);

        // GPIO transition to segment 3 selected by GPIO_IN[2]
        bus.REP[3] = 16'd0;
        bus.TRANSITION_VALUE = 64'd2;
        bus.GPIO_IN = 4'b1011;
        do_update(3, M_GPIO);
        sync_step(3, 1);
        sync_step(3, 2);
        check("gpio_wait_busy", 64'(bus.BUSY), 1);
        check("gpio_wait_seg", 64'(bus.SEGMENT), 1);
        bus.GPIO_IN = 4'b0100;
        step();
        check("gpio_no_change", 64'(bus.BUSY), 1);
        sync_step(3, 3);
        check("gpio_fired_seg", 64'(bus.SEGMENT), 3);
        check("gpio_fired_busy", 64'(bus.BUSY), 0);
        check("gpio_idx_start", 64'(bus.IDX[3]), 0);

        // EXT round-robin over mask 1011
        bus.EXT_MASK = 4'b1011;
        bus.REP[0] = '1;
        do_update(0, M_EXT);
        check("ext_seg0", 64'(bus.SEGMENT), 0);
        check("ext_stop_clr", 64'(bus.STOP), 0);
        sync_step(0, 1);
        check("ext_nonzero_hold", 64'(bus.SEGMENT), 0);
        sync_step(0, 0);
        check("ext_0_to_1", 64'(bus.SEGMENT), 1);
        sync_step(1, 0);
        check("ext_1_to_3", 64'(bus.SEGMENT), 3);
        sync_step(3, 0);
        check("ext_3_to_0", 64'(bus.SEGMENT), 0);
        bus.EXT_MASK = 4'b0001;
        sync_step(0, 2);
        sync_step(0, 0);
        check("ext_single_hold", 64'(bus.SEGMENT), 0);

        // New request coinciding with a trigger wins and restarts the wait
        bus.TRANSITION_VALUE = '0;
        bus.REP[2] = 16'd1;
        do_update(2, M_SYNC);
        sync_step(2, 1);
        check("ovr_busy", 64'(bus.BUSY), 1);
        bus.REP[1] = 16'd0;
        bus.SYNC_IDX[2] = 15'd0;
        do_update(1, M_SYNC);
        check("ovr_not_seg2", 64'(bus.SEGMENT), 0);
        check("ovr_still_busy", 64'(bus.BUSY), 1);
        sync_step(1, 1);
        sync_step(1, 0);
        check("ovr_seg1", 64'(bus.SEGMENT), 1);
        sync_step(1, 1);
        sync_step(1, 0);
        check("ovr_rep0_stop", 64'(bus.STOP), 1);

        // IMMEDIATE with finite REP switches at once and plays one loop
        bus.REP[2] = 16'd0;
        do_update(2, M_IMM);
        check("imm_seg", 64'(bus.SEGMENT), 2);
        check("imm_stop_clr", 64'(bus.STOP), 0);
        check("imm_busy", 64'(bus.BUSY), 0);
        sync_step(2, 1);
        sync_step(2, 0);
        check("imm_stop", 64'(bus.STOP), 1);
        check("imm_done", 64'(bus.DONE), 1);

        // Reset during WAIT_START
        bus.REP[3] = 16'd1;
        do_update(3, M_SYNC);
        check("rst2_busy_before", 64'(bus.BUSY), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_segment", 64'(bus.SEGMENT), 0);
        check("rst2_busy", 64'(bus.BUSY), 0);
        check("rst2_stop", 64'(bus.STOP), 0);
        check("rst2_done", 64'(bus.DONE), 0);
        step();
        rst_n = 1'b1;
        sync_step(3, 0);
        check("rst2_after_done", 64'(bus.DONE), 0);
        check("rst2_after_seg", 64'(bus.SEGMENT), 0);
        check("rst2_after_busy", 64'(bus.BUSY), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/segment_swapchain_n.md
Name: segment_swapchain_n

Overview:
- Parametrised N-segment swapchain that selects which buffered segment (modulation or STM) drives playback.
- Produces per-segment read indices and a stop flag for the downstream sampler.
- Generalises the two-segment modulation swapchain:
  - arbitrary segment count and index/repeat widths;
  - an IMMEDIATE transition mode;
  - round-robin EXT cycling over a segment mask;
  - explicit STOPPED state with DONE/BUSY status.
- Sits between the controller settings registers and the per-segment readers.

Parameters:
- NUM_SEGMENT, 4, number of segments (>=2); SEG_W = $clog2(NUM_SEGMENT).
- IDX_WIDTH, 15, sample index width.
- REP_WIDTH, 16, repeat-count width; all-ones means infinite.
- NUM_GPIO, 4, GPIO trigger inputs; GPIO_W = $clog2(NUM_GPIO).
- LATENCY, 5, pipeline depth of the 64-bit SYS_TIME subtractor.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- SYS_TIME  in  64  system time.
- UPDATE_SETTINGS  in  1  one-cycle request strobe.
- REQ_RD_SEGMENT  in  SEG_W  requested segment.
- TRANSITION_MODE  in  8  params::TRANSITION_MODE_{SYNC_IDX,SYS_TIME,GPIO,EXT,IMMEDIATE}.
- TRANSITION_VALUE  in  64  target time, or GPIO select in bits [GPIO_W-1:0].
- CYCLE[NUM_SEGMENT]  in  IDX_WIDTH  last index of each segment.
- REP[NUM_SEGMENT]  in  REP_WIDTH  repeat count per segment.
- SYNC_IDX[NUM_SEGMENT]  in  IDX_WIDTH  timer-synchronised index per segment.
- GPIO_IN  in  NUM_GPIO  external triggers.
- EXT_MASK  in  NUM_SEGMENT  segments eligible for EXT cycling.
- SEGMENT  out  SEG_W  active segment.
- IDX[NUM_SEGMENT]  out  IDX_WIDTH  read index per segment.
- STOP  out  1  finite playback finished.
- BUSY  out  1  transition pending (state WAIT_START).
- DONE  out  1  one-cycle pulse when STOP rises.

Behaviour:
- Reset values (async, RST_N low):
  - SEGMENT=0, STOP=0, BUSY=0, DONE=0.
  - state=INFINITE_LOOP, idx_mode=SYNC_IDX, ext_mode=0.
  - idx_old[*]=0, tic_idx[*]=0, loop_cnt=0.
- Index path:
  - idx_old[i] registers SYNC_IDX[i] every cycle.
  - changed[i] = (idx_old[i] != SYNC_IDX[i]).
  - IDX[i] = idx_mode==SYNC_IDX ? idx_old[i] : tic_idx[i].
- States: INFINITE_LOOP, WAIT_START, FINITE_LOOP, STOPPED. BUSY = (state==WAIT_START).
- UPDATE_SETTINGS:
  - Highest priority; it overrides any event in the same cycle and restarts a pending WAIT_START.
  - If REQ_RD_SEGMENT >= NUM_SEGMENT, the request is ignored.
  - If REP[req] is all-ones, or mode is IMMEDIATE:
    - switch next cycle: SEGMENT=req, STOP=0, idx_mode=SYNC_IDX;
    - ext_mode = (mode==EXT);
    - state=INFINITE_LOOP, or FINITE_LOOP with loop_cnt=0 when IMMEDIATE and REP finite.
  - Otherwise: latch req/rep, diff_cnt=LATENCY-1, state=WAIT_START.
- WAIT_START triggers. On firing: SEGMENT=req, STOP=0, loop_cnt=0, state=FINITE_LOOP.
  - SYNC_IDX mode: fires on changed[req] && SYNC_IDX[req]==0. idx_mode=SYNC_IDX.
  - SYS_TIME mode: diff = SYS_TIME - TRANSITION_VALUE, signed 65-bit.
    - diff_cnt decrements to 0 first; then fires when diff >= 0.
    - On firing: idx_mode=TIC, tic_idx[req]=0.
  - GPIO mode: fires on changed[req] && GPIO_IN[TRANSITION_VALUE[GPIO_W-1:0]].
    - On firing: idx_mode=TIC, tic_idx[req]=0.
  - Any other mode: wait indefinitely.
- INFINITE_LOOP:
  - If ext_mode && changed[SEGMENT] && SYNC_IDX[SEGMENT]==0, SEGMENT advances to the next set bit of EXT_MASK, circularly above SEGMENT.
  - If no other bit is set, SEGMENT stays.
- FINITE_LOOP loop-end:
  - SYNC idx_mode: changed && SYNC_IDX==0.
  - TIC idx_mode: on changed, tic_idx increments; when tic_idx==CYCLE it wraps to 0, and that wrap is the loop-end.
  - At loop-end: if loop_cnt==rep, then STOP=1, DONE=1 for one cycle, state=STOPPED; else loop_cnt+1.
  - REP=0 therefore plays exactly one loop.
- STOPPED:
  - tic_idx frozen; SEGMENT held; STOP held.
  - Leaves only on UPDATE_SETTINGS.
- Reset mid-operation returns to the reset values immediately, with no DONE pulse.

Test Plan:
- Reset then idle; SYNC_IDX[0] ramps -> SEGMENT=0, IDX[0]=SYNC_IDX[0] delayed 1 cycle, STOP=0, BUSY=0.
- NUM_SEGMENT=4; UPDATE req=2, REP=1, SYNC_IDX mode -> BUSY until SYNC_IDX[2] wraps to 0. Then SEGMENT=2, STOP rises after the 2nd wrap, DONE pulses once.
- SYS_TIME mode, TRANSITION_VALUE=1000, SYS_TIME counting from 990 -> switch no earlier than LATENCY cycles after UPDATE, once SYS_TIME>=1000. IDX[req] starts at 0 and wraps at CYCLE=3 (0,1,2,3,0). REP=0 gives STOP after 4 ticks.
- GPIO mode, value=2 -> no switch while GPIO_IN[2]=0; switch on the first SYNC_IDX change with GPIO_IN[2]=1.
- EXT mode, REP all-ones, EXT_MASK=4'b1011, start seg 0 -> wrap sequence 0->1->3->0; mask 4'b0001 keeps 0.
- UPDATE_SETTINGS coinciding with a trigger, and RST_N pulsed low during WAIT_START -> new request wins; reset returns all outputs to reset values with no DONE.
